// File: rtl/apu_pkg.sv
// rtl/apu_pkg.sv - shared step-entry field layout and sequencer state encoding
package apu_pkg;
   localparam int NOTE_W       = 6;
   localparam int FX_W         = 2;
   localparam int STEP_ENTRY_W = 9;

   localparam int GATE_BIT = 8;
   localparam int FX_MSB   = 7;
   localparam int FX_LSB   = 6;
   localparam int NOTE_MSB = 5;

   typedef enum logic {
      SEQ_STOP = 1'b0,
      SEQ_RUN  = 1'b1
   } seq_state_t;
endpackage

// File: rtl/seq_pattern_ram.sv
// rtl/seq_pattern_ram.sv - pattern store, sync write / sync read, read-before-write
module seq_pattern_ram
   import apu_pkg::*;
#(
   parameter int ADDR_W = 4
)(
   input  logic                    clk,
   input  logic                    wr_en,
   input  logic [ADDR_W-1:0]       wr_addr,
   input  logic [STEP_ENTRY_W-1:0] wr_data,
   input  logic [ADDR_W-1:0]       rd_addr,
   output logic [STEP_ENTRY_W-1:0] rd_data
);
   logic [STEP_ENTRY_W-1:0] r_mem [2**ADDR_W];
   logic [STEP_ENTRY_W-1:0] r_rd_data;

   // Not reset: the pattern must survive a mid-playback reset.
   always_ff @(posedge clk) begin
      if (wr_en)
         r_mem[wr_addr] <= wr_data;
      r_rd_data <= r_mem[rd_addr];
   end

   assign rd_data = r_rd_data;
endmodule

// File: rtl/note_step_sequencer.sv
// rtl/note_step_sequencer.sv - 16-step pattern sequencer and note_clk divider; SEQ_LOOP_LEN_EN adds loop_len
module note_step_sequencer
   import apu_pkg::*;
#(
   parameter int STEP_BITS    = 4,
   parameter int PERIOD_W     = 24,
   parameter int NOTE_CLK_DIV = 390625
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    stop,
   input  logic [PERIOD_W-1:0]     step_period,
   input  logic                    wr_en,
   input  logic [STEP_BITS-1:0]    wr_addr,
   input  logic [STEP_ENTRY_W-1:0] wr_data,
`ifdef SEQ_LOOP_LEN_EN
   input  logic [STEP_BITS-1:0]    loop_len,
`endif
   output logic [NOTE_W-1:0]       note_out,
   output logic                    gate_out,
   output logic [FX_W-1:0]         fx_sel_out,
   output logic [STEP_BITS-1:0]    step_idx,
   output logic                    step_pulse,
   output logic                    running,
   output logic                    note_clk
);
   localparam int DIV_W = $clog2(NOTE_CLK_DIV + 1);

   seq_state_t              r_state, w_state_nxt;
   logic [PERIOD_W-1:0]     r_tick_cnt;
   logic [STEP_BITS-1:0]    r_step_idx;
   logic [NOTE_W-1:0]       r_note;
   logic [FX_W-1:0]         r_fx;
   logic                    r_gate;
   logic                    r_step_pulse;
   logic [DIV_W-1:0]        r_div_cnt;
   logic                    r_note_clk;

   logic [PERIOD_W-1:0]     w_eff_period;
   logic                    w_tick_term;
   logic [STEP_BITS-1:0]    w_next_idx;
   logic [STEP_BITS-1:0]    w_rd_addr;
   logic [STEP_ENTRY_W-1:0] w_rd_data;

   assign w_eff_period = (step_period < PERIOD_W'(2)) ? PERIOD_W'(2) : step_period;
   assign w_tick_term  = (r_tick_cnt >= w_eff_period - PERIOD_W'(1));

`ifdef SEQ_LOOP_LEN_EN
   assign w_next_idx = (r_step_idx >= loop_len) ? '0 : r_step_idx + STEP_BITS'(1);
`else
   assign w_next_idx = r_step_idx + STEP_BITS'(1);
`endif

   // Prefetch the next step while running; park on step 0 whenever the next edge lands in STOP,
   // so a restart right after stop/rst still presents step 0.
   assign w_rd_addr = (r_state == SEQ_RUN && !stop && !rst) ? w_next_idx : '0;

   seq_pattern_ram #(.ADDR_W(STEP_BITS)) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (w_rd_addr),
      .rd_data (w_rd_data)
   );

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= SEQ_STOP;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         SEQ_STOP: if (start && !stop) w_state_nxt = SEQ_RUN;
         SEQ_RUN:  if (stop)           w_state_nxt = SEQ_STOP;
         default:                      w_state_nxt = SEQ_STOP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tick_cnt   <= '0;
         r_step_idx   <= '0;
         r_note       <= '0;
         r_fx         <= '0;
         r_gate       <= 1'b0;
         r_step_pulse <= 1'b0;
      end else if (w_state_nxt == SEQ_STOP) begin
         r_tick_cnt   <= '0;
         r_step_idx   <= '0;
         r_gate       <= 1'b0;
         r_step_pulse <= 1'b0;
      end else if (r_state == SEQ_STOP || w_tick_term) begin
         r_tick_cnt   <= '0;
         r_step_idx   <= (r_state == SEQ_STOP) ? '0 : w_next_idx;
         r_note       <= w_rd_data[NOTE_MSB:0];
         r_fx         <= w_rd_data[FX_MSB:FX_LSB];
         r_gate       <= w_rd_data[GATE_BIT];
         r_step_pulse <= 1'b1;
      end else begin
         r_tick_cnt   <= r_tick_cnt + PERIOD_W'(1);
         r_step_pulse <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_div_cnt  <= '0;
         r_note_clk <= 1'b0;
      end else if (r_div_cnt == DIV_W'(NOTE_CLK_DIV - 1)) begin
         r_div_cnt  <= '0;
         r_note_clk <= ~r_note_clk;
      end else begin
         r_div_cnt  <= r_div_cnt + DIV_W'(1);
      end
   end

   assign note_out   = r_note;
   assign gate_out   = r_gate;
   assign fx_sel_out = r_fx;
   assign step_idx   = r_step_idx;
   assign step_pulse = r_step_pulse;
   assign running    = (r_state == SEQ_RUN);
   assign note_clk   = r_note_clk;
endmodule

// File: tb/tb_note_step_sequencer.sv
// tb/tb_note_step_sequencer.sv - directed self-checking bench for note_step_sequencer
module tb_note_step_sequencer;
   logic        clk = 1'b0;
   logic        rst, start, stop, wr_en;
   logic [23:0] step_period;
   logic [3:0]  wr_addr;
   logic [8:0]  wr_data;
`ifdef SEQ_LOOP_LEN_EN
   logic [3:0]  loop_len = 4'd15;
`endif
   logic [5:0]  note_out;
   logic        gate_out;
   logic [1:0]  fx_sel_out;
   logic [3:0]  step_idx;
   logic        step_pulse, running, note_clk;

   logic [8:0]  model [16];
   int          passed = 0;
   int          total  = 0;

   always #5 clk = ~clk;

   note_step_sequencer #(.STEP_BITS(4), .PERIOD_W(24), .NOTE_CLK_DIV(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .step_period (step_period),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
`ifdef SEQ_LOOP_LEN_EN
      .loop_len    (loop_len),
`endif
      .note_out    (note_out),
      .gate_out    (gate_out),
      .fx_sel_out  (fx_sel_out),
      .step_idx    (step_idx),
      .step_pulse  (step_pulse),
      .running     (running),
      .note_clk    (note_clk)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic chk_step(input string tag, input int idx, input int pulse);
      logic [8:0] e;
      e = model[idx];
      chk({tag, ".idx"},     int'(step_idx),   idx);
      chk({tag, ".note"},    int'(note_out),   int'(e[5:0]));
      chk({tag, ".gate"},    int'(gate_out),   int'(e[8]));
      chk({tag, ".fx"},      int'(fx_sel_out), int'(e[7:6]));
      chk({tag, ".pulse"},   int'(step_pulse), pulse);
      chk({tag, ".running"}, int'(running),    1);
   endtask

   task automatic chk_stopped(input string tag);
      chk({tag, ".running"}, int'(running),    0);
      chk({tag, ".gate"},    int'(gate_out),   0);
      chk({tag, ".idx"},     int'(step_idx),   0);
      chk({tag, ".pulse"},   int'(step_pulse), 0);
   endtask

   initial begin
      logic [3:0] iv;
      rst = 1'b1; start = 1'b0; stop = 1'b0; wr_en = 1'b0;
      wr_addr = '0; wr_data = '0; step_period = 24'd4;
      tick(2);
      chk_stopped("reset");
      chk("reset.note",    int'(note_out),   0);
      chk("reset.fx",      int'(fx_sel_out), 0);
      chk("reset.noteclk", int'(note_clk),   0);

      // note_clk with divide-by-5: toggles on the 5th, 10th ... edge after reset
      rst = 1'b0;
      tick(4);  chk("noteclk.e4",  int'(note_clk), 0);
      tick(1);  chk("noteclk.e5",  int'(note_clk), 1);
      tick(4);  chk("noteclk.e9",  int'(note_clk), 1);
      tick(1);  chk("noteclk.e10", int'(note_clk), 0);

      for (int i = 0; i < 16; i++) begin
         iv = 4'(i);
         model[i] = {iv[0], iv[2:1], 6'(i + 1)};
         wr_en = 1'b1; wr_addr = iv; wr_data = model[i];
         tick(1);
      end
      wr_en = 1'b0;

      // 1: full pass at period 4, including wrap 15 -> 0
      start = 1'b1; tick(1); start = 1'b0;
      chk_step("t1.first", 0, 1);
      for (int s = 1; s <= 16; s++) begin
         for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("t1.hold.pulse", int'(step_pulse), 0);
            chk("t1.hold.idx",   int'(step_idx),   (s - 1) % 16);
         end
         tick(1);
         chk_step("t1.step", s % 16, 1);
      end

      // 2: stop mid step 5, immediate restart
      tick(22);
      chk("t2.at5", int'(step_idx), 5);
      stop = 1'b1; tick(1); stop = 1'b0;
      chk_stopped("t2.stop");
      chk("t2.note_hold", int'(note_out), 6);
      start = 1'b1; tick(1); start = 1'b0;
      chk_step("t2.restart", 0, 1);

      // 3: short periods clamp to 2; shrinking period past tick advances next cycle
      step_period = 24'd0;
      tick(1); chk("t3.p0.hold", int'(step_pulse), 0);
      tick(1); chk_step("t3.p0.s1", 1, 1);
      tick(2); chk_step("t3.p0.s2", 2, 1);
      step_period = 24'd1;
      tick(1); chk("t3.p1.hold", int'(step_pulse), 0);
      tick(1); chk_step("t3.p1.s3", 3, 1);
      step_period = 24'd10;
      tick(6);
      chk("t3.p10.pulse", int'(step_pulse), 0);
      chk("t3.p10.idx",   int'(step_idx),   3);
      step_period = 24'd3;
      tick(1); chk_step("t3.shrink", 4, 1);

      // 4: write step 3 during last cycle of step 2
      step_period = 24'd4;
      stop = 1'b1; tick(1); stop = 1'b0;
      start = 1'b1; tick(1); start = 1'b0;
      chk_step("t4.start", 0, 1);
      tick(11);
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = {1'b1, 2'b10, 6'd50};
      tick(1);
      wr_en = 1'b0;
      chk_step("t4.old", 3, 1);
      model[3] = {1'b1, 2'b10, 6'd50};
      tick(64);
      chk_step("t4.new", 3, 1);

      // 5: start+stop together, then reset during playback
      stop = 1'b1; tick(1); stop = 1'b0;
      start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0;
      chk_stopped("t5.both");
      tick(3);
      chk("t5.idle", int'(running), 0);
      start = 1'b1; tick(1); start = 1'b0;
      chk_step("t5.run", 0, 1);
      tick(6);
      rst = 1'b1; tick(1); rst = 1'b0;
      chk_stopped("t5.rst");
      chk("t5.rst.note",    int'(note_out),   0);
      chk("t5.rst.fx",      int'(fx_sel_out), 0);
      chk("t5.rst.noteclk", int'(note_clk),   0);
      start = 1'b1; tick(1); start = 1'b0;
      chk_step("t5.after.s0", 0, 1);
      tick(12);
      chk_step("t5.after.s3", 3, 1);

`ifdef SEQ_LOOP_LEN_EN
      // 6: loop length 3, then lowered to 1 while on step 2
      stop = 1'b1; tick(1); stop = 1'b0;
      loop_len = 4'd3;
      start = 1'b1; tick(1); start = 1'b0;
      chk_step("t6.s0", 0, 1);
      tick(4); chk_step("t6.s1", 1, 1);
      tick(4); chk_step("t6.s2", 2, 1);
      tick(4); chk_step("t6.s3", 3, 1);
      tick(4); chk_step("t6.wrap", 0, 1);
      tick(8); chk_step("t6.at2", 2, 1);
      loop_len = 4'd1;
      tick(4); chk_step("t6.cut", 0, 1);
      tick(4); chk_step("t6.l1.s1", 1, 1);
      tick(4); chk_step("t6.l1.s0", 0, 1);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
